// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle ALU feeding the Z/HI/LO registers.
//
// Single-cycle ops (logic, add/sub, shift/rotate, neg/not) finish on the
// start edge. MUL (radix-2 Booth) and DIV (restoring, on magnitudes) each
// iterate WIDTH times in RUN. The result is presented as {zhi, zlo}.
//
// Ports:
//   clk          system clock, rising edge
//   Clear        synchronous active-low reset, highest priority
//   start        request, sampled only in IDLE
//   op[3:0]      operation code, latched with start
//   a, b         operands (Y register / bus), latched with start
//   busy         high while iterating (RUN)
//   done         one-cycle pulse; zlo/zhi valid from here until next start
//   zlo, zhi     result low / high word (quotient / remainder for DIV)
//   div_by_zero  set with done for DIV by zero, cleared on next start
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] zlo,
    output logic [WIDTH-1:0] zhi,
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_ROR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_NEG = 4'd8;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_DIV = 4'd11;

    logic [1:0]       r_state;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    // MUL: r_acc is Booth's A (one guard bit so most-negative squared fits),
    //      r_q the multiplier, r_m the sign-extended multiplicand.
    // DIV: r_acc is the partial remainder, r_q the dividend shifting into
    //      the quotient, r_m the divisor magnitude.
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [WIDTH:0]   r_m;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_zlo;
    logic [WIDTH-1:0] r_zhi;
    logic             r_dbz;

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]     w_sh;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_rsh;
    logic [2*WIDTH-1:0] w_lsh;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;

    assign w_sh  = b[SHW-1:0];
    assign w_sum = {1'b0, a} + {1'b0, b};
    // Shifting {a,a} gives both the plain shift (one half) and the rotate
    // (the other half) from a single shifter per direction.
    assign w_rsh = {a, a} >> w_sh;
    assign w_lsh = {a, a} << w_sh;

    assign w_a_abs = a[WIDTH-1] ? -a : a;
    assign w_b_abs = b[WIDTH-1] ? -b : b;

    always_comb begin
        w_lo = '0;
        w_hi = '0;
        case (op)
            OP_AND: w_lo = a & b;
            OP_OR:  w_lo = a | b;
            OP_ADD: begin
                w_lo = w_sum[WIDTH-1:0];
                w_hi = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            end
            OP_SUB: begin
                w_lo = a - b;
                w_hi = {{(WIDTH-1){1'b0}}, (a < b)};
            end
            OP_SHR: w_lo = w_rsh[2*WIDTH-1:WIDTH];
            OP_SHL: w_lo = w_lsh[WIDTH-1:0];
            OP_ROR: w_lo = w_rsh[WIDTH-1:0];
            OP_ROL: w_lo = w_lsh[2*WIDTH-1:WIDTH];
            OP_NEG: w_lo = -b;
            OP_NOT: w_lo = ~b;
            default: begin
                w_lo = '0;
                w_hi = '0;
            end
        endcase
    end

    // ---------------- iterative step ----------------
    logic [WIDTH:0]   w_bsum;
    logic [WIDTH:0]   w_dshift;
    logic [WIDTH:0]   w_dtrial;
    logic [WIDTH:0]   w_acc_n;
    logic [WIDTH-1:0] w_q_n;
    logic             w_q1_n;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    always_comb begin
        case ({r_q[0], r_q1})
            2'b01:   w_bsum = r_acc + r_m;
            2'b10:   w_bsum = r_acc - r_m;
            default: w_bsum = r_acc;
        endcase
    end

    // Partial remainder stays below the divisor, so the shifted value fits
    // in WIDTH bits and bit WIDTH of the trial is a clean borrow flag.
    assign w_dshift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_dtrial = w_dshift - r_m;

    always_comb begin
        w_acc_n = r_acc;
        w_q_n   = r_q;
        w_q1_n  = 1'b0;
        if (r_is_div) begin
            if (!w_dtrial[WIDTH]) begin
                w_acc_n = w_dtrial;
                w_q_n   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_n = w_dshift;
                w_q_n   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // arithmetic right shift of {A, Q, q-1}
            w_acc_n = {w_bsum[WIDTH], w_bsum[WIDTH:1]};
            w_q_n   = {w_bsum[0], r_q[WIDTH-1:1]};
            w_q1_n  = r_q[0];
        end
    end

    assign w_rem_mag = w_acc_n[WIDTH-1:0];
    assign w_quo     = r_neg_q ? -w_q_n : w_q_n;
    assign w_rem     = r_neg_r ? -w_rem_mag : w_rem_mag;

    // ---------------- control ----------------
    always_ff @(posedge clk) begin
        if (!Clear) begin
            r_state  <= S_IDLE;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_q1     <= 1'b0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_zlo    <= '0;
            r_zhi    <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dbz    <= 1'b0;
                        r_is_div <= (op == OP_DIV);
                        r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_r  <= a[WIDTH-1];
                        r_cnt    <= CW'(WIDTH);
                        if (op == OP_MUL) begin
                            r_acc   <= '0;
                            r_q     <= b;
                            r_q1    <= 1'b0;
                            r_m     <= {a[WIDTH-1], a};
                            r_state <= S_RUN;
                        end else if (op == OP_DIV) begin
                            if (b == '0) begin
                                r_zlo   <= '0;
                                r_zhi   <= a;
                                r_dbz   <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_acc   <= '0;
                                r_q     <= w_a_abs;
                                r_q1    <= 1'b0;
                                r_m     <= {1'b0, w_b_abs};
                                r_state <= S_RUN;
                            end
                        end else begin
                            r_zlo   <= w_lo;
                            r_zhi   <= w_hi;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_n;
                    r_q   <= w_q_n;
                    r_q1  <= w_q1_n;
                    r_cnt <= r_cnt - 1'b1;
                    // outputs are only touched on the final iteration
                    if (r_cnt == CW'(1)) begin
                        r_zlo   <= r_is_div ? w_quo : w_q_n;
                        r_zhi   <= r_is_div ? w_rem : w_acc_n[WIDTH-1:0];
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign zlo         = r_zlo;
    assign zhi         = r_zhi;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH=32): directed cases plus a
// randomized run compared against a plain-arithmetic reference model.
module tb_alu_seq_unit;

    logic        clk = 1'b0;
    logic        Clear;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] zlo;
    logic [31:0] zhi;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .Clear(Clear), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .zlo(zlo), .zhi(zhi),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: {zhi, zlo} from ordinary integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] f_op,
                                          input logic [31:0] fa,
                                          input logic [31:0] fb);
        logic [31:0] lo;
        logic [31:0] hi;
        longint sa;
        longint sb;
        longint t;
        int s;
        lo = 32'd0;
        hi = 32'd0;
        sa = $signed(fa);
        sb = $signed(fb);
        s  = int'(fb % 32);
        case (f_op)
            4'd0: lo = fa & fb;
            4'd1: lo = fa | fb;
            4'd2: begin
                t  = longint'({32'd0, fa}) + longint'({32'd0, fb});
                lo = t[31:0];
                hi = t[63:32];
            end
            4'd3: begin
                lo = fa - fb;
                hi = (fa < fb) ? 32'd1 : 32'd0;
            end
            4'd4: lo = fa >> s;
            4'd5: lo = fa << s;
            4'd6: lo = (s == 0) ? fa : ((fa >> s) | (fa << (32 - s)));
            4'd7: lo = (s == 0) ? fa : ((fa << s) | (fa >> (32 - s)));
            4'd8: lo = -fb;
            4'd9: lo = ~fb;
            4'd10: begin
                t  = sa * sb;
                lo = t[31:0];
                hi = t[63:32];
            end
            4'd11: begin
                if (fb == 32'd0) begin
                    lo = 32'd0;
                    hi = fa;
                end else begin
                    t  = sa / sb;
                    lo = t[31:0];
                    t  = sa % sb;
                    hi = t[31:0];
                end
            end
            default: ;
        endcase
        return {hi, lo};
    endfunction

    function automatic int exp_lat(input logic [3:0] f_op, input logic [31:0] fb);
        return (f_op == 4'd10 || (f_op == 4'd11 && fb != 32'd0)) ? 33 : 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request and run to done. Returns cycles from the start cycle
    // to the done cycle (100 means done never came), how many cycles busy
    // was seen, and whether zlo/zhi held their old value until done.
    // With poke set, random requests are thrown at the DUT while busy.
    task automatic exec(input logic [3:0] t_op, input logic [31:0] ta,
                        input logic [31:0] tbv, input bit poke,
                        output int lat, output int nbusy, output bit held);
        logic [31:0] plo;
        logic [31:0] phi;
        lat = 0;
        nbusy = 0;
        held = 1'b1;
        @(negedge clk);
        plo = zlo;
        phi = zhi;
        start = 1'b1;
        op = t_op;
        a = ta;
        b = tbv;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            if (zlo !== plo || zhi !== phi) held = 1'b0;
            if (poke && busy) begin
                start = 1'($urandom_range(0, 1));
                op = 4'($urandom_range(0, 9));
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset();
        Clear = 1'b0;
        start = 1'b0;
        op = 4'd0;
        a = 32'd0;
        b = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b dbz=%b want 0 0 0", busy, done, div_by_zero);
        end
        checks++;
        if (zlo !== 32'd0 || zhi !== 32'd0) begin
            errors++;
            $display("FAIL reset_z: zlo=%h zhi=%h want 0 0", zlo, zhi);
        end
        Clear = 1'b1;
    endtask

    task automatic test_or();
        int lat, nb;
        bit hd;
        exec(4'd1, 32'd30, 32'd25, 1'b0, lat, nb, hd);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL or_latency: got %0d want 1", lat);
        end
        checks++;
        if (zlo !== 32'd31 || zhi !== 32'd0) begin
            errors++;
            $display("FAIL or_result: zlo=%h zhi=%h want 1f 0", zlo, zhi);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL or_done_pulse: done=%b want 0 one cycle later", done);
        end
    endtask

    task automatic test_add_carry();
        int lat, nb;
        bit hd;
        exec(4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, nb, hd);
        checks++;
        if (zlo !== 32'd0 || zhi !== 32'd1) begin
            errors++;
            $display("FAIL add_carry: zlo=%h zhi=%h want 0 1", zlo, zhi);
        end
    endtask

    task automatic test_shift_rotate();
        int lat, nb;
        bit hd;
        exec(4'd6, 32'd1, 32'd1, 1'b0, lat, nb, hd);
        checks++;
        if (zlo !== 32'h8000_0000 || zhi !== 32'd0) begin
            errors++;
            $display("FAIL ror_1: zlo=%h zhi=%h want 80000000 0", zlo, zhi);
        end
        exec(4'd5, 32'd1, 32'd33, 1'b0, lat, nb, hd);
        checks++;
        if (zlo !== 32'd2) begin
            errors++;
            $display("FAIL shl_33: zlo=%h want 2", zlo);
        end
        exec(4'd7, 32'h8000_0001, 32'd4, 1'b0, lat, nb, hd);
        checks++;
        if (zlo !== 32'h0000_0018) begin
            errors++;
            $display("FAIL rol_4: zlo=%h want 18", zlo);
        end
        exec(4'd4, 32'hDEAD_BEEF, 32'd64, 1'b0, lat, nb, hd);
        checks++;
        if (zlo !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL shr_0: zlo=%h want deadbeef", zlo);
        end
    endtask

    task automatic test_mul();
        int lat, nb;
        bit hd;
        exec(4'd10, -32'sd6, 32'd7, 1'b1, lat, nb, hd);
        checks++;
        if (nb !== 32 || lat !== 33) begin
            errors++;
            $display("FAIL mul_timing: busy=%0d lat=%0d want 32 33", nb, lat);
        end
        checks++;
        if (!hd) begin
            errors++;
            $display("FAIL mul_hold: outputs changed during RUN, want held");
        end
        checks++;
        if (zlo !== 32'hFFFF_FFD6 || zhi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mul_result: zlo=%h zhi=%h want ffffffd6 ffffffff", zlo, zhi);
        end
        exec(4'd10, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, nb, hd);
        checks++;
        if (zlo !== 32'd0 || zhi !== 32'h4000_0000) begin
            errors++;
            $display("FAIL mul_minmin: zlo=%h zhi=%h want 0 40000000", zlo, zhi);
        end
    endtask

    task automatic test_div();
        int lat, nb;
        bit hd;
        exec(4'd11, -32'sd7, 32'd2, 1'b1, lat, nb, hd);
        checks++;
        if (lat !== 33 || nb !== 32) begin
            errors++;
            $display("FAIL div_timing: lat=%0d busy=%0d want 33 32", lat, nb);
        end
        checks++;
        if (zlo !== 32'hFFFF_FFFD || zhi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_result: zlo=%h zhi=%h want fffffffd ffffffff", zlo, zhi);
        end
        exec(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, nb, hd);
        checks++;
        if (zlo !== 32'h8000_0000 || zhi !== 32'd0) begin
            errors++;
            $display("FAIL div_min_neg1: zlo=%h zhi=%h want 80000000 0", zlo, zhi);
        end
    endtask

    task automatic test_div_zero();
        int lat, nb;
        bit hd;
        exec(4'd11, 32'd9, 32'd0, 1'b0, lat, nb, hd);
        checks++;
        if (lat !== 1 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_flag: lat=%0d dbz=%b want 1 1", lat, div_by_zero);
        end
        checks++;
        if (zlo !== 32'd0 || zhi !== 32'd9) begin
            errors++;
            $display("FAIL dbz_result: zlo=%h zhi=%h want 0 9", zlo, zhi);
        end
        @(negedge clk);
        checks++;
        if (div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_hold: dbz=%b want 1 until next start", div_by_zero);
        end
        exec(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat, nb, hd);
        checks++;
        if (div_by_zero !== 1'b0 || zlo !== 32'hF000_F000) begin
            errors++;
            $display("FAIL dbz_clear: dbz=%b zlo=%h want 0 f000f000", div_by_zero, zlo);
        end
    endtask

    task automatic test_illegal();
        int lat, nb;
        bit hd;
        exec(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, lat, nb, hd);
        checks++;
        if (lat !== 1 || zlo !== 32'd0 || zhi !== 32'd0) begin
            errors++;
            $display("FAIL illegal_op: lat=%0d zlo=%h zhi=%h want 1 0 0", lat, zlo, zhi);
        end
    endtask

    task automatic test_clear_during_run();
        int lat, nb;
        bit hd;
        exec(4'd1, 32'd30, 32'd25, 1'b0, lat, nb, hd);
        @(negedge clk);
        start = 1'b1;
        op = 4'd10;
        a = 32'd123;
        b = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || zlo !== 32'd31) begin
            errors++;
            $display("FAIL clr_pre: busy=%b zlo=%h want 1 1f", busy, zlo);
        end
        Clear = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || zlo !== 32'd0 || zhi !== 32'd0) begin
            errors++;
            $display("FAIL clr_abort: busy=%b done=%b zlo=%h zhi=%h want 0 0 0 0", busy, done, zlo, zhi);
        end
        Clear = 1'b1;
        exec(4'd1, 32'd30, 32'd25, 1'b0, lat, nb, hd);
        checks++;
        if (lat !== 1 || zlo !== 32'd31) begin
            errors++;
            $display("FAIL clr_recover: lat=%0d zlo=%h want 1 1f", lat, zlo);
        end
    endtask

    task automatic test_random();
        int lat, nb;
        bit hd;
        logic [3:0]  r_op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            r_op = 4'($urandom_range(0, 15));
            ra = pick();
            rb = (r_op == 4'd11 && $urandom_range(0, 5) == 0) ? 32'd0 : pick();
            exp = model(r_op, ra, rb);
            exec(r_op, ra, rb, 1'b0, lat, nb, hd);
            checks++;
            if ({zhi, zlo} !== exp) begin
                errors++;
                $display("FAIL rand_result op=%0d a=%h b=%h: got %h_%h want %h_%h",
                         r_op, ra, rb, zhi, zlo, exp[63:32], exp[31:0]);
            end
            checks++;
            if (lat !== exp_lat(r_op, rb) || !hd) begin
                errors++;
                $display("FAIL rand_timing op=%0d: lat=%0d held=%b want %0d 1",
                         r_op, lat, hd, exp_lat(r_op, rb));
            end
            checks++;
            if (div_by_zero !== (r_op == 4'd11 && rb == 32'd0)) begin
                errors++;
                $display("FAIL rand_dbz op=%0d b=%h: got %b", r_op, rb, div_by_zero);
            end
        end
    endtask

    initial begin
        test_reset();
        test_or();
        test_add_carry();
        test_shift_rotate();
        test_mul();
        test_div();
        test_div_zero();
        test_illegal();
        test_clear_during_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Parametrised multi-cycle ALU that supersedes the single-cycle OR/ADD path feeding the Z register. It sits between the Y register (operand A), the bus (operand B) and the Z/HI/LO registers. It executes logic, arithmetic, shift/rotate, signed multiply and signed divide under a start/busy/done handshake. Results are presented as a {zhi, zlo} pair for Zhiout/Zlowout.

Parameters:
WIDTH, 32, datapath word width; power of two, minimum 4. Shift-amount width SHW = log2(WIDTH) is derived internally.

Ports:
clk  input  1  system clock; all state changes on rising edge
Clear  input  1  synchronous, active-low reset
start  input  1  request; sampled only in IDLE
op  input  4  operation code, latched with start
a  input  WIDTH  operand A (from Y), latched with start
b  input  WIDTH  operand B (from bus), latched with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; zlo/zhi valid from this cycle until the next start
zlo  output  WIDTH  result low word / quotient
zhi  output  WIDTH  result high word / remainder / carry
div_by_zero  output  1  set with done for DIV with b==0; cleared on next accepted start

Behaviour:
- Clock and reset: one clock, clk; reset is Clear, synchronous and active-low.
- Reset: Clear==0 at a rising edge forces state IDLE and sets zlo=0, zhi=0, busy=0, done=0, div_by_zero=0. It takes priority over everything, including a multiply/divide in RUN, whose partial result is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start==1: latch op/a/b and clear div_by_zero.
    - Single-cycle op: write zlo/zhi on that edge and go to DONE.
    - MUL/DIV (b!=0): load accumulators, set count=WIDTH, go to RUN.
    - DIV with b==0: go straight to DONE.
  - RUN: one iteration per cycle; busy=1; count decrements. At the edge where count reaches 0, write zlo/zhi and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in RUN and DONE; no queuing.
- Latency from the start edge to done high: 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL/DIV.
- Op codes (zhi=0 unless stated):
  - 0 AND: a&b.
  - 1 OR: a|b.
  - 2 ADD: zlo=a+b; zhi=carry-out in bit 0.
  - 3 SUB: zlo=a-b; zhi=borrow in bit 0 (unsigned a<b).
  - 4 SHR: logical a>>b[SHW-1:0].
  - 5 SHL: a<<b[SHW-1:0].
  - 6 ROR, 7 ROL: rotate a by b[SHW-1:0].
  - 8 NEG: -b.
  - 9 NOT: ~b.
  - 10 MUL: signed radix-2 Booth, a*b, 2*WIDTH-bit product as {zhi,zlo}.
  - 11 DIV: signed, restoring division on magnitudes. zlo=quotient truncated toward zero; zhi=remainder carrying the sign of a.
  - 12-15: illegal; go to DONE with zlo=zhi=0.
- Shift amount: only the low SHW bits of b are used, so an amount of WIDTH+k behaves as k. An amount of 0 returns a unchanged.
- Width/overflow rules:
  - MUL of most-negative by most-negative yields the exact 2*WIDTH-bit product.
  - DIV of most-negative by -1 yields zlo=most-negative, zhi=0.
- Divide by zero: zlo=0, zhi=a, div_by_zero=1, latency 1.
- Output holding: zlo/zhi change only on result write or reset. Intermediate RUN values are never visible on the outputs.
- Start and Clear on the same edge: Clear wins; start is lost.

Test Plan:
- WIDTH=32, reset held 2 cycles, then OR a=30, b=25 -> one cycle after start, done=1, zlo=31, zhi=0; done low the following cycle.
- ADD a=0xFFFFFFFF, b=1 -> zlo=0, zhi=1.
- ROR a=1, b=1 -> zlo=0x80000000. SHL a=1, b=33 -> zlo=2.
- MUL a=-6, b=7:
  - busy=1 for 32 cycles and start pulses during busy are ignored.
  - done 33 cycles after start.
  - zlo=0xFFFFFFD6, zhi=0xFFFFFFFF.
- DIV a=-7, b=2 -> zlo=0xFFFFFFFD, zhi=0xFFFFFFFF after 33 cycles.
- DIV a=9, b=0 -> 1-cycle done, div_by_zero=1, zlo=0, zhi=9; next start clears div_by_zero.
- Clear low at the 10th RUN cycle of a MUL -> next cycle busy=0, done=0, zlo=zhi=0. A following OR a=30, b=25 completes normally with zlo=31.
